// File: rtl/obuf_drain_pkg.sv
// Shared lane widths and per-lane requantisation helpers (round/shift, saturate).
// Used by obuf_requant_drain; ReLU is gated there by OBUF_REQUANT_RELU_EN.
package obuf_drain_pkg;

   localparam int ACC_W   = 48;
   localparam int OUT_W   = 16;
   localparam int SHIFT_W = 6;

   typedef struct packed {
      logic             sat;
      logic [OUT_W-1:0] val;
   } sat_res_t;

   // Round half up then arithmetic shift; one extra bit keeps acc + 2^(s-1) exact.
   function automatic logic signed [ACC_W:0] round_shift(input logic [ACC_W-1:0]   acc,
                                                         input logic [SHIFT_W-1:0] sh);
      logic signed [ACC_W:0] ext;
      logic signed [ACC_W:0] bias;
      ext  = signed'({acc[ACC_W-1], acc});
      bias = '0;
      if (sh != '0) bias[sh - 1'b1] = 1'b1;
      return (ext + bias) >>> sh;
   endfunction

   // In range when every bit from the result sign bit upward matches the sign.
   function automatic sat_res_t sat_out(input logic [ACC_W:0] r);
      sat_res_t                 res;
      logic [ACC_W-OUT_W+1:0]   hi;
      hi      = r[ACC_W:OUT_W-1];
      res.sat = !((&hi) || !(|hi));
      if (res.sat) res.val = r[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      else         res.val = r[OUT_W-1:0];
      return res;
   endfunction

endpackage

// File: rtl/drain_fifo.sv
// First-word-fall-through FIFO: rd_data shows the head entry (zero when empty);
// a pop takes effect at the clock edge. Push and pop together on a full FIFO is legal.
module drain_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             wr_en, rd_en;

   always_comb begin
      rd_en    = pop && (count_q != '0);
      wr_en    = push && ((count_q != CNT_W'(DEPTH)) || rd_en);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/obuf_requant_drain.sv
// Requantises the systolic array's output-buffer write stream into a valid/ready stream.
// Build option: define OBUF_REQUANT_RELU_EN to honour cfg_relu.
module obuf_requant_drain
   import obuf_drain_pkg::*;
#(
   parameter int ARRAY_M         = 4,
   parameter int ACC_WIDTH       = ACC_W,
   parameter int OUT_DATA_WIDTH  = OUT_W,
   parameter int OBUF_ADDR_WIDTH = 16,
   parameter int SHIFT_WIDTH     = SHIFT_W,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [SHIFT_WIDTH-1:0]              cfg_shift,
   input  logic                                cfg_relu,
   input  logic                                sys_obuf_write_req,
   input  logic [OBUF_ADDR_WIDTH-1:0]          sys_obuf_write_addr,
   input  logic [ARRAY_M*ACC_WIDTH-1:0]        obuf_write_data,
   output logic                                drain_stall,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [OBUF_ADDR_WIDTH-1:0]          out_addr,
   output logic [ARRAY_M*OUT_DATA_WIDTH-1:0]   out_data,
   output logic [15:0]                         sat_count,
   output logic                                overflow_err
);

   // Handshakes: a beat is accepted when sys_obuf_write_req && !drain_stall; an output
   // entry transfers when out_valid && out_ready, and out_* hold while out_valid && !out_ready.

   localparam int DATA_W = ARRAY_M * OUT_DATA_WIDTH;
   localparam int FIFO_W = OBUF_ADDR_WIDTH + DATA_W;
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int SAT_W  = $clog2(ARRAY_M + 1);

   logic                         s1_valid_q, s1_valid_d;
   logic [OBUF_ADDR_WIDTH-1:0]   s1_addr_q, s1_addr_d;
   logic [ARRAY_M*ACC_WIDTH-1:0] s1_data_q, s1_data_d;
   logic [SHIFT_WIDTH-1:0]       s1_shift_q, s1_shift_d;
   logic                         s1_relu_q, s1_relu_d;
   logic [15:0]                  sat_count_q, sat_count_d;
   logic                         overflow_q, overflow_d;

   sat_res_t                     lane_res [ARRAY_M];
   logic [DATA_W-1:0]            res_data;
   logic [SAT_W-1:0]             sat_add;
   logic [16:0]                  sat_sum;
   logic [CNT_W-1:0]             fifo_count;
   logic [CNT_W:0]               occupancy;
   logic                         fifo_empty, accept, pop;
   logic [FIFO_W-1:0]            fifo_rd;

   // Stage 2 is combinational in front of the FIFO write port, so its valid is s1_valid_q.
   assign occupancy   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid_q};
   assign drain_stall = (occupancy >= (CNT_W+1)'(FIFO_DEPTH));
   assign accept      = sys_obuf_write_req && !drain_stall;

   always_comb begin
      s1_valid_d = accept;
      s1_addr_d  = accept ? sys_obuf_write_addr : s1_addr_q;
      s1_data_d  = accept ? obuf_write_data     : s1_data_q;
      s1_shift_d = accept ? cfg_shift           : s1_shift_q;
      s1_relu_d  = accept ? cfg_relu            : s1_relu_q;
      overflow_d = overflow_q || (sys_obuf_write_req && drain_stall);
   end

   always_comb begin
      res_data = '0;
      sat_add  = '0;
      for (int i = 0; i < ARRAY_M; i++) begin
         lane_res[i] = sat_out(round_shift(s1_data_q[i*ACC_WIDTH +: ACC_WIDTH], s1_shift_q));
         res_data[i*OUT_DATA_WIDTH +: OUT_DATA_WIDTH] = lane_res[i].val;
`ifdef OBUF_REQUANT_RELU_EN
         if (s1_relu_q && lane_res[i].val[OUT_DATA_WIDTH-1])
            res_data[i*OUT_DATA_WIDTH +: OUT_DATA_WIDTH] = '0;
`endif
         sat_add = sat_add + SAT_W'(lane_res[i].sat);
      end
      sat_sum     = {1'b0, sat_count_q} + 17'(sat_add);
      sat_count_d = sat_count_q;
      if (s1_valid_q) sat_count_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
   end

`ifndef OBUF_REQUANT_RELU_EN
   logic relu_unused;
   assign relu_unused = s1_relu_q;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid_q  <= 1'b0;
         s1_addr_q   <= '0;
         s1_data_q   <= '0;
         s1_shift_q  <= '0;
         s1_relu_q   <= 1'b0;
         sat_count_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_addr_q   <= s1_addr_d;
         s1_data_q   <= s1_data_d;
         s1_shift_q  <= s1_shift_d;
         s1_relu_q   <= s1_relu_d;
         sat_count_q <= sat_count_d;
         overflow_q  <= overflow_d;
      end
   end

   assign pop = !fifo_empty && out_ready;

   drain_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push    (s1_valid_q),
      .wr_data ({s1_addr_q, res_data}),
      .pop     (pop),
      .rd_data (fifo_rd),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign out_valid    = !fifo_empty;
   assign out_addr     = fifo_rd[FIFO_W-1 -: OBUF_ADDR_WIDTH];
   assign out_data     = fifo_rd[DATA_W-1:0];
   assign sat_count    = sat_count_q;
   assign overflow_err = overflow_q;

endmodule
